// File: rtl/cpu_pkg.sv
// Shared core types for the pipeline control logic.
package cpu_pkg;

  // Register-specifier width for the 16-register core.
  localparam int unsigned REG_W = 4;

  // Hazard sequencer states.
  typedef enum logic [1:0] {
    RUN,
    LU_BUBBLE,
    IFETCH_WAIT,
    DFREEZE
  } hz_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use compare between the load in EX and the instruction in ID.
// A match that exists only on Rt of a store is store data, which MEM-MEM forwarding
// covers, so it does not raise a hazard.
module hazard_detect #(
  parameter int unsigned REG_W = cpu_pkg::REG_W
) (
  input  logic             i_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_uses_rt,
  input  logic             i_id_is_store,
  output logic             o_lu
);

  logic w_rs_hit;
  logic w_rt_hit;
  logic w_store_data_only;

  assign w_rs_hit          = (i_ex_rd == i_id_rs);
  assign w_rt_hit          = (i_ex_rd == i_id_rt) && i_id_uses_rt;
  assign w_store_data_only = w_rt_hit && !w_rs_hit && i_id_is_store;

  assign o_lu = i_mem_read && (w_rs_hit || w_rt_hit) && !w_store_data_only;

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: per-cycle write enables, bubbles, flushes and PC control.
// Optional stall counters are built when HAZ_STALL_COUNT_EN is defined.
module hazard_controller
  import cpu_pkg::*;
#(
  parameter int unsigned REG_W = cpu_pkg::REG_W
`ifdef HAZ_STALL_COUNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] IF_ID_RegisterRs,
  input  logic [REG_W-1:0] IF_ID_RegisterRt,
  input  logic             IF_ID_UsesRt,
  input  logic             IF_ID_IsStore,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_RegisterRd,
  input  logic             BranchTaken,
  input  logic             ICacheStall,
  input  logic             DCacheStall,
  output logic             PC_write,
  output logic             IF_ID_write,
  output logic             IF_ID_flush,
  output logic             ID_EX_write,
  output logic             ID_EX_flush,
  output logic             EX_MEM_write,
  output logic             MEM_WB_write,
  output logic             Redirect
`ifdef HAZ_STALL_COUNT_EN
  ,
  output logic [CNT_W-1:0] BubbleCount,
  output logic [CNT_W-1:0] FreezeCount,
  output logic [CNT_W-1:0] FetchWaitCount
`endif
);

  hz_state_t r_state;
  hz_state_t w_state_nxt;
  logic      r_redir_pending;
  logic      w_redir_pending_nxt;
  logic      w_lu_raw;
  logic      w_lu;

  hazard_detect #(
    .REG_W(REG_W)
  ) u_hazard_detect (
    .i_mem_read   (ID_EX_MemRead),
    .i_ex_rd      (ID_EX_RegisterRd),
    .i_id_rs      (IF_ID_RegisterRs),
    .i_id_rt      (IF_ID_RegisterRt),
    .i_id_uses_rt (IF_ID_UsesRt),
    .i_id_is_store(IF_ID_IsStore),
    .o_lu         (w_lu_raw)
  );

  // The load still sits in EX for the cycle after its bubble; mask it to give one bubble.
  assign w_lu = w_lu_raw && (r_state != LU_BUBBLE);

  // State and pending-redirect registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= RUN;
      r_redir_pending <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_redir_pending <= w_redir_pending_nxt;
    end
  end

  // Next state and enables, priority DCacheStall > lu > BranchTaken > ICacheStall.
  always_comb begin
    PC_write            = 1'b1;
    IF_ID_write         = 1'b1;
    IF_ID_flush         = 1'b0;
    ID_EX_write         = 1'b1;
    ID_EX_flush         = 1'b0;
    EX_MEM_write        = 1'b1;
    MEM_WB_write        = 1'b1;
    Redirect            = 1'b0;
    w_state_nxt         = RUN;
    w_redir_pending_nxt = r_redir_pending;

    if (DCacheStall) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      w_state_nxt  = DFREEZE;
    end else if (w_lu) begin
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      ID_EX_flush = 1'b1;
      w_state_nxt = LU_BUBBLE;
    end else begin
      if (BranchTaken) begin
        IF_ID_flush = 1'b1;
        // Target is held until the outstanding fetch returns.
        if (ICacheStall) w_redir_pending_nxt = 1'b1;
        else             Redirect            = 1'b1;
      end
      if (ICacheStall) begin
        PC_write    = 1'b0;
        IF_ID_flush = 1'b1;
        w_state_nxt = (r_state == LU_BUBBLE) ? RUN : IFETCH_WAIT;
      end else if (r_redir_pending) begin
        // Fetch returned on the wrong path: drop it and steer to the held target.
        IF_ID_flush         = 1'b1;
        Redirect            = 1'b1;
        w_redir_pending_nxt = 1'b0;
      end
    end

    if (rst) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      IF_ID_flush  = 1'b1;
      ID_EX_write  = 1'b0;
      ID_EX_flush  = 1'b1;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      Redirect     = 1'b0;
    end
  end

`ifdef HAZ_STALL_COUNT_EN
  logic w_cnt_bubble;
  logic w_cnt_fetch_wait;

  assign w_cnt_bubble     = !DCacheStall && w_lu;
  assign w_cnt_fetch_wait = !DCacheStall && !w_lu && ICacheStall;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      BubbleCount    <= '0;
      FreezeCount    <= '0;
      FetchWaitCount <= '0;
    end else begin
      if (w_cnt_bubble && (BubbleCount != '1))         BubbleCount    <= BubbleCount + 1'b1;
      if (DCacheStall && (FreezeCount != '1))          FreezeCount    <= FreezeCount + 1'b1;
      if (w_cnt_fetch_wait && (FetchWaitCount != '1))  FetchWaitCount <= FetchWaitCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller; expected enable vectors are queued as
// stimulus is applied and popped when the outputs are sampled mid-cycle.
module tb_hazard_controller;

  typedef struct packed {
    logic       dc;
    logic       ic;
    logic       br;
    logic       mr;
    logic [3:0] rd;
    logic [3:0] rs;
    logic [3:0] rt;
    logic       ut;
    logic       st;
  } stim_t;

  // {PC_write, IF_ID_write, IF_ID_flush, ID_EX_write, ID_EX_flush, EX_MEM_write,
  //  MEM_WB_write, Redirect}
  localparam logic [7:0] E_DEF = 8'b1101_0110;
  localparam logic [7:0] E_LU  = 8'b0001_1110;
  localparam logic [7:0] E_FRZ = 8'b0000_0000;
  localparam logic [7:0] E_IC  = 8'b0111_0110;
  localparam logic [7:0] E_BR  = 8'b1111_0111;
  localparam logic [7:0] E_RST = 8'b0010_1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] rs, rt, rd;
  logic       ut, st, mr, br, ic, dc;
  logic       pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, redir;
  logic [7:0] w_outs;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];

`ifdef HAZ_STALL_COUNT_EN
  logic [15:0] bub_cnt, frz_cnt, fw_cnt;
`endif

  hazard_controller dut (
    .clk             (clk),
    .rst             (rst),
    .IF_ID_RegisterRs(rs),
    .IF_ID_RegisterRt(rt),
    .IF_ID_UsesRt    (ut),
    .IF_ID_IsStore   (st),
    .ID_EX_MemRead   (mr),
    .ID_EX_RegisterRd(rd),
    .BranchTaken     (br),
    .ICacheStall     (ic),
    .DCacheStall     (dc),
    .PC_write        (pc_w),
    .IF_ID_write     (ifid_w),
    .IF_ID_flush     (ifid_f),
    .ID_EX_write     (idex_w),
    .ID_EX_flush     (idex_f),
    .EX_MEM_write    (exmem_w),
    .MEM_WB_write    (memwb_w),
    .Redirect        (redir)
`ifdef HAZ_STALL_COUNT_EN
    ,
    .BubbleCount     (bub_cnt),
    .FreezeCount     (frz_cnt),
    .FetchWaitCount  (fw_cnt)
`endif
  );

  assign w_outs = {pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, memwb_w, redir};

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  function automatic stim_t mk(logic dc_, logic ic_, logic br_, logic mr_, logic [3:0] rd_,
                               logic [3:0] rs_, logic [3:0] rt_, logic ut_, logic st_);
    stim_t s;
    s = '{dc: dc_, ic: ic_, br: br_, mr: mr_, rd: rd_, rs: rs_, rt: rt_, ut: ut_, st: st_};
    return s;
  endfunction

  task automatic drive(input stim_t s);
    dc = s.dc; ic = s.ic; br = s.br; mr = s.mr;
    rd = s.rd; rs = s.rs; rt = s.rt; ut = s.ut; st = s.st;
  endtask

  localparam stim_t IDLE = '0;

  task automatic test_reset();
    logic [7:0] e;
    drive(IDLE);
    sb.push_back(E_RST);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (w_outs !== e) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", w_outs, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(IDLE);
    sb.push_back(E_DEF);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (w_outs !== e) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", w_outs, e);
    end
  endtask

  task automatic test_load_use();
    stim_t      s[10];
    logic [7:0] x[10];
    logic [7:0] e;
    s[0] = mk(0, 0, 0, 1, 4'd3, 4'd3, 4'd0, 0, 0); x[0] = E_LU;
    s[1] = s[0];                                    x[1] = E_DEF;
    s[2] = IDLE;                                    x[2] = E_DEF;
    s[3] = mk(0, 0, 0, 1, 4'd7, 4'd1, 4'd7, 1, 0); x[3] = E_LU;
    s[4] = IDLE;                                    x[4] = E_DEF;
    s[5] = mk(0, 0, 0, 1, 4'd7, 4'd1, 4'd7, 0, 0); x[5] = E_DEF;
    s[6] = mk(0, 0, 0, 1, 4'd0, 4'd0, 4'd5, 1, 0); x[6] = E_LU;
    s[7] = IDLE;                                    x[7] = E_DEF;
    s[8] = mk(0, 0, 0, 1, 4'd4, 4'd4, 4'd4, 1, 1); x[8] = E_LU;
    s[9] = IDLE;                                    x[9] = E_DEF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL load_use step %0d: got %b expected %b", i, w_outs, e);
      end
    end
  endtask

  task automatic test_store_data();
    stim_t      s[3];
    logic [7:0] x[3];
    logic [7:0] e;
    s[0] = mk(0, 0, 0, 1, 4'd3, 4'd5, 4'd3, 1, 1); x[0] = E_DEF;
    s[1] = s[0];                                    x[1] = E_DEF;
    s[2] = mk(0, 0, 0, 0, 4'd3, 4'd3, 4'd3, 1, 0); x[2] = E_DEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL store_data step %0d: got %b expected %b", i, w_outs, e);
      end
    end
  endtask

  task automatic test_branch_icache();
    stim_t      s[10];
    logic [7:0] x[10];
    logic [7:0] e;
    s[0] = mk(0, 0, 1, 0, 4'd0, 4'd1, 4'd2, 0, 0); x[0] = E_BR;
    s[1] = IDLE;                                    x[1] = E_DEF;
    s[2] = mk(0, 1, 1, 0, 4'd0, 4'd1, 4'd2, 0, 0); x[2] = E_IC;
    s[3] = s[2];                                    x[3] = E_IC;
    s[4] = s[2];                                    x[4] = E_IC;
    s[5] = IDLE;                                    x[5] = E_BR;
    s[6] = IDLE;                                    x[6] = E_DEF;
    s[7] = mk(0, 1, 0, 0, 4'd0, 4'd1, 4'd2, 0, 0); x[7] = E_IC;
    s[8] = s[7];                                    x[8] = E_IC;
    s[9] = IDLE;                                    x[9] = E_DEF;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL branch_icache step %0d: got %b expected %b", i, w_outs, e);
      end
    end
  endtask

  task automatic test_lu_branch();
    stim_t      s[3];
    logic [7:0] x[3];
    logic [7:0] e;
    s[0] = mk(0, 0, 1, 1, 4'd3, 4'd3, 4'd0, 0, 0); x[0] = E_LU;
    s[1] = mk(0, 0, 1, 0, 4'd0, 4'd3, 4'd0, 0, 0); x[1] = E_BR;
    s[2] = IDLE;                                    x[2] = E_DEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL lu_branch step %0d: got %b expected %b", i, w_outs, e);
      end
    end
  endtask

  task automatic test_dfreeze();
    stim_t      s[7];
    logic [7:0] x[7];
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      s[i] = mk(1, 0, 0, 1, 4'd6, 4'd6, 4'd0, 0, 0);
      x[i] = E_FRZ;
    end
    s[4] = mk(0, 0, 0, 1, 4'd6, 4'd6, 4'd0, 0, 0); x[4] = E_LU;
    s[5] = s[4];                                    x[5] = E_DEF;
    s[6] = IDLE;                                    x[6] = E_DEF;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      drive(s[i]);
      sb.push_back(x[i]);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL dfreeze step %0d: got %b expected %b", i, w_outs, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e;
    // Enter IFETCH_WAIT with a redirect pending.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      drive(mk(0, 1, (i == 0), 0, 4'd0, 4'd1, 4'd2, 0, 0));
      sb.push_back(E_IC);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (w_outs !== e) begin
        n_fail++;
        $display("FAIL reset_mid setup %0d: got %b expected %b", i, w_outs, e);
      end
    end
    #2;
    rst = 1'b1;
    sb.push_back(E_RST);
    #1;
    e = sb.pop_front();
    n_checks++;
    if (w_outs !== e) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected %b", w_outs, e);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(IDLE);
    sb.push_back(E_DEF);
    @(negedge clk);
    e = sb.pop_front();
    n_checks++;
    if (w_outs !== e) begin
      n_fail++;
      $display("FAIL reset_mid_release: got %b expected %b", w_outs, e);
    end
`ifdef HAZ_STALL_COUNT_EN
    n_checks++;
    if ({bub_cnt, frz_cnt, fw_cnt} !== 48'd0) begin
      n_fail++;
      $display("FAIL reset_counters: got %h %h %h expected 0 0 0", bub_cnt, frz_cnt, fw_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_store_data();
    test_branch_icache();
    test_lu_branch();
    test_dfreeze();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
